v16_filter_ctrl: RTL and testbench
==================================

// Module: v16_filter_ctrl
// PURPOSE
//  Configuration and sequencing controller for the v16 trapezoidal shaping filter (k, l, m1, m2).
//  Holds a host-writable shadow set of coefficients and validates it on request.
//  Swaps it atomically into the active set, holds the filter in reset for a flush period,
//  then masks the filter output until the pipeline has refilled. Sits between the host register bus and the filter.
// PARAMETERS
//  PAR_W       16  width of each coefficient register
//  K_DEF       16  reset value of k (shadow and active)
//  L_DEF       24  reset value of l (shadow and active)
//  M1_DEF      1   reset value of m1
//  M2_DEF      8   reset value of m2
//  MAX_WIN     63  largest legal l (depth of filter sample store)
//  FLUSH_CYC   4   cycles filter reset is held low per apply (>=1)
//  PIPE_LAT    6   filter pipeline latency added to the settle time
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  reset       in   1      synchronous, active-low reset
//  cfg_wr      in   1      write strobe for shadow register
//  cfg_addr    in   2      0=k 1=l 2=m1 3=m2
//  cfg_wdata   in   PAR_W  write data
//  cfg_apply   in   1      request: validate shadow set and load it into the filter
//  cfg_busy    out  1      high in FLUSH and SETTLE
//  cfg_err     out  1      one-cycle pulse: apply rejected, shadow set illegal
//  k_out,l_out,m1_out,m2_out out PAR_W  active coefficients driven to filter
//  filt_reset  out  1      active-low reset to filter datapath
//  data_valid  out  1      high when filter output is meaningful
// BEHAVIOUR
//  - reset=0 at an edge: shadow and active <= defaults; state <= FLUSH, flush counter <= FLUSH_CYC;
//    filt_reset=0, cfg_busy=1, data_valid=0, cfg_err=0. Reset mid-operation aborts any sequence the same way.
//  - cfg_wr: shadow[cfg_addr] <= cfg_wdata next edge, in any state; active set untouched.
//  - States: FLUSH -> SETTLE -> RUN.
//    FLUSH: filt_reset=0; count FLUSH_CYC cycles, then SETTLE with settle counter <= l_out + PIPE_LAT.
//    SETTLE: filt_reset=1, data_valid=0; count down; at zero -> RUN.
//    RUN: filt_reset=1, data_valid=1, cfg_busy=0.
//  - cfg_apply in RUN: legal iff 1<=k, k<l, l<=MAX_WIN (m1, m2 unrestricted).
//    Legal: active <= shadow and state <= FLUSH on the same edge; data_valid falls and filt_reset goes low
//    the next cycle. Illegal: cfg_err=1 for one cycle, state and active unchanged.
//  - cfg_apply while cfg_busy=1: ignored, no error, not queued.
//  - cfg_wr and cfg_apply in the same cycle: apply uses the shadow value before that write; the write
//    lands in shadow only and needs a later apply.
//  - Active coefficients change only on the apply edge, never mid-RUN.
//  - Settle arithmetic: PAR_W-bit unsigned; l_out <= MAX_WIN guarantees no overflow.
//  - data_valid is registered and never high while filt_reset=0.
// TESTING
//  1 Release reset at edge 0 -> filt_reset=0 for edges 1..4, SETTLE 30 cycles, data_valid=1 from edge 35;
//    k/l/m1/m2 = 16/24/1/8.
//  2 In RUN write k=10 l=40 m1=2 m2=4, pulse apply -> outputs 10/40/2/4 next cycle, busy=1,
//    filt_reset low 4 cycles, data_valid back after 4+46 cycles.
//  3 Shadow l=k=20, apply in RUN -> cfg_err pulses 1 cycle, active unchanged, data_valid stays 1.
//  4 Shadow l=64, apply -> cfg_err; then l=63, apply -> accepted, settle 69 cycles.
//  5 Apply during SETTLE -> ignored, no err, counter unaffected; same-cycle wr(k=5)+apply -> old k used.
//  6 reset=0 for one cycle mid-SETTLE after shadow writes -> defaults restored, full 4+30 restart.

Source files
------------

// File: rtl/v16_filter_ctrl_if.sv
// Host-side configuration bus and filter-side control bundle for the v16 filter controller.
interface v16_filter_ctrl_if #(
  parameter int PAR_W = 16
);
  logic             cfg_wr;
  logic [1:0]       cfg_addr;
  logic [PAR_W-1:0] cfg_wdata;
  logic             cfg_apply;
  logic             cfg_busy;
  logic             cfg_err;
  logic [PAR_W-1:0] k_out;
  logic [PAR_W-1:0] l_out;
  logic [PAR_W-1:0] m1_out;
  logic [PAR_W-1:0] m2_out;
  logic             filt_reset;
  logic             data_valid;

  modport master (
    output cfg_wr, cfg_addr, cfg_wdata, cfg_apply,
    input  cfg_busy, cfg_err, k_out, l_out, m1_out, m2_out, filt_reset, data_valid
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_wdata, cfg_apply,
    output cfg_busy, cfg_err, k_out, l_out, m1_out, m2_out, filt_reset, data_valid
  );
endinterface

// File: rtl/v16_filter_ctrl.sv
// Shadow/active coefficient controller for the v16 trapezoidal filter: validates and
// swaps the coefficient set, flushes the filter, then masks output until it has refilled.
module v16_filter_ctrl #(
  parameter int PAR_W     = 16,
  parameter int K_DEF     = 16,
  parameter int L_DEF     = 24,
  parameter int M1_DEF    = 1,
  parameter int M2_DEF    = 8,
  parameter int MAX_WIN   = 63,
  parameter int FLUSH_CYC = 4,
  parameter int PIPE_LAT  = 6
) (
  input  logic              clk,
  input  logic              reset,
  v16_filter_ctrl_if.slave  bus
);

  localparam int FW = $clog2(FLUSH_CYC + 1);

  typedef enum logic [1:0] {
    ST_FLUSH  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [FW-1:0]    flush_cnt_r, flush_cnt_s;
  logic [PAR_W-1:0] settle_cnt_r, settle_cnt_s;
  logic             load_s, err_s;
  logic             frst_s, dv_s, busy_s;
  logic             frst_r, dv_r, busy_r, err_r;
  logic [PAR_W-1:0] k_sh_r, l_sh_r, m1_sh_r, m2_sh_r;
  logic [PAR_W-1:0] k_act_r, l_act_r, m1_act_r, m2_act_r;

  function automatic logic cfg_legal(input logic [PAR_W-1:0] k, input logic [PAR_W-1:0] l);
    return (k >= PAR_W'(1)) && (k < l) && (l <= PAR_W'(MAX_WIN));
  endfunction

  // Next-state and counter logic; only an apply in RUN can start a new sequence.
  always_comb begin
    state_s      = state_r;
    flush_cnt_s  = flush_cnt_r;
    settle_cnt_s = settle_cnt_r;
    load_s       = 1'b0;
    err_s        = 1'b0;
    case (state_r)
      ST_FLUSH: begin
        if (flush_cnt_r <= FW'(1)) begin
          state_s      = ST_SETTLE;
          settle_cnt_s = l_act_r + PAR_W'(PIPE_LAT);
        end else begin
          flush_cnt_s = flush_cnt_r - FW'(1);
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_r == PAR_W'(0)) begin
          state_s = ST_RUN;
        end else begin
          settle_cnt_s = settle_cnt_r - PAR_W'(1);
        end
      end
      ST_RUN: begin
        if (bus.cfg_apply) begin
          if (cfg_legal(k_sh_r, l_sh_r)) begin
            load_s      = 1'b1;
            state_s     = ST_FLUSH;
            flush_cnt_s = FW'(FLUSH_CYC);
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s     = ST_FLUSH;
        flush_cnt_s = FW'(FLUSH_CYC);
      end
    endcase
  end

  // Output decode from the next state so the registered outputs track the state register.
  always_comb begin
    frst_s = 1'b1;
    dv_s   = 1'b0;
    busy_s = 1'b1;
    case (state_s)
      ST_FLUSH: begin
        frst_s = 1'b0;
      end
      ST_SETTLE: begin
        frst_s = 1'b1;
      end
      ST_RUN: begin
        dv_s   = 1'b1;
        busy_s = 1'b0;
      end
      default: begin
        frst_s = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_FLUSH;
      flush_cnt_r  <= FW'(FLUSH_CYC);
      settle_cnt_r <= PAR_W'(0);
      frst_r       <= 1'b0;
      dv_r         <= 1'b0;
      busy_r       <= 1'b1;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      flush_cnt_r  <= flush_cnt_s;
      settle_cnt_r <= settle_cnt_s;
      frst_r       <= frst_s;
      dv_r         <= dv_s;
      busy_r       <= busy_s;
      err_r        <= err_s;
    end
  end

  // Shadow set: host writes land here in any state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      k_sh_r  <= PAR_W'(K_DEF);
      l_sh_r  <= PAR_W'(L_DEF);
      m1_sh_r <= PAR_W'(M1_DEF);
      m2_sh_r <= PAR_W'(M2_DEF);
    end else if (bus.cfg_wr) begin
      case (bus.cfg_addr)
        2'd0:    k_sh_r  <= bus.cfg_wdata;
        2'd1:    l_sh_r  <= bus.cfg_wdata;
        2'd2:    m1_sh_r <= bus.cfg_wdata;
        2'd3:    m2_sh_r <= bus.cfg_wdata;
        default: k_sh_r  <= k_sh_r;
      endcase
    end
  end

  // Active set: copied from shadow (pre-write values) only on an accepted apply.
  always_ff @(posedge clk) begin
    if (!reset) begin
      k_act_r  <= PAR_W'(K_DEF);
      l_act_r  <= PAR_W'(L_DEF);
      m1_act_r <= PAR_W'(M1_DEF);
      m2_act_r <= PAR_W'(M2_DEF);
    end else if (load_s) begin
      k_act_r  <= k_sh_r;
      l_act_r  <= l_sh_r;
      m1_act_r <= m1_sh_r;
      m2_act_r <= m2_sh_r;
    end
  end

  assign bus.k_out      = k_act_r;
  assign bus.l_out      = l_act_r;
  assign bus.m1_out     = m1_act_r;
  assign bus.m2_out     = m2_act_r;
  assign bus.filt_reset = frst_r;
  assign bus.data_valid = dv_r;
  assign bus.cfg_busy   = busy_r;
  assign bus.cfg_err    = err_r;

endmodule

// File: tb/tb_v16_filter_ctrl.sv
// Scoreboard bench for v16_filter_ctrl: each sequence start pushes the expected active set
// and latency; the entry is popped and compared when data_valid is seen.
module tb_v16_filter_ctrl;

  typedef struct packed {
    logic [15:0] k;
    logic [15:0] l;
    logic [15:0] m1;
    logic [15:0] m2;
    logic [31:0] lat;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   t0;
  int   n_cmp;
  int   n_bad;
  exp_t sb_q[$];

  v16_filter_ctrl_if #(.PAR_W(16)) bus ();

  v16_filter_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] addr, input logic [15:0] data);
    bus.cfg_wr    = 1'b1;
    bus.cfg_addr  = addr;
    bus.cfg_wdata = data;
    @(negedge clk);
    bus.cfg_wr    = 1'b0;
  endtask

  task automatic apply(input bit mark);
    bus.cfg_apply = 1'b1;
    @(negedge clk);
    bus.cfg_apply = 1'b0;
    if (mark) t0 = cyc;
  endtask

  function automatic exp_t mk(input int k, input int l, input int m1, input int m2);
    exp_t e;
    e.k   = 16'(k);
    e.l   = 16'(l);
    e.m1  = 16'(m1);
    e.m2  = 16'(m2);
    e.lat = 32'(l + 11);
    return e;
  endfunction

  // Wait for data_valid, counting filt_reset-low samples, then pop and compare.
  task automatic wait_run(input string tag, input int lo_exp);
    exp_t e;
    int   lo;
    bit   seen;
    lo   = 0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (!bus.filt_reset) lo++;
      if (bus.data_valid) seen = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_timeout"}, 32'(seen), 32'd1);
    chk({tag, "_flush"}, 32'(lo), 32'(lo_exp));
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_lat"}, 32'(cyc - t0), e.lat);
      chk({tag, "_k"},  32'(bus.k_out),  32'(e.k));
      chk({tag, "_l"},  32'(bus.l_out),  32'(e.l));
      chk({tag, "_m1"}, 32'(bus.m1_out), 32'(e.m1));
      chk({tag, "_m2"}, 32'(bus.m2_out), 32'(e.m2));
      chk({tag, "_busy"}, 32'(bus.cfg_busy), 32'd0);
    end
  endtask

  task automatic apply_bad(input string tag, input int k_now);
    apply(1'b0);
    chk({tag, "_err"}, 32'(bus.cfg_err), 32'd1);
    chk({tag, "_dv"}, 32'(bus.data_valid), 32'd1);
    chk({tag, "_k"}, 32'(bus.k_out), 32'(k_now));
    @(negedge clk);
    chk({tag, "_err_pulse"}, 32'(bus.cfg_err), 32'd0);
    chk({tag, "_dv2"}, 32'(bus.data_valid), 32'd1);
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    cyc           = 0;
    t0            = 0;
    reset         = 1'b0;
    bus.cfg_wr    = 1'b0;
    bus.cfg_addr  = 2'd0;
    bus.cfg_wdata = 16'd0;
    bus.cfg_apply = 1'b0;

    // 1: reset release
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    t0    = cyc;
    chk("rst_frst", 32'(bus.filt_reset), 32'd0);
    chk("rst_busy", 32'(bus.cfg_busy), 32'd1);
    chk("rst_dv",   32'(bus.data_valid), 32'd0);
    chk("rst_err",  32'(bus.cfg_err), 32'd0);
    sb_q.push_back(mk(16, 24, 1, 8));
    wait_run("boot", 4);

    // 2: legal reconfiguration
    wr(2'd0, 16'd10);
    wr(2'd1, 16'd40);
    wr(2'd2, 16'd2);
    wr(2'd3, 16'd4);
    sb_q.push_back(mk(10, 40, 2, 4));
    apply(1'b1);
    chk("app_k",    32'(bus.k_out), 32'd10);
    chk("app_busy", 32'(bus.cfg_busy), 32'd1);
    chk("app_dv",   32'(bus.data_valid), 32'd0);
    wait_run("cfg1", 4);

    // 3: k == l rejected
    wr(2'd0, 16'd20);
    wr(2'd1, 16'd20);
    apply_bad("keql", 10);

    // 4: l above window rejected, l at window accepted
    wr(2'd1, 16'd64);
    apply_bad("lmax", 10);
    wr(2'd1, 16'd63);
    sb_q.push_back(mk(20, 63, 2, 4));
    apply(1'b1);
    for (int i = 0; i < 10; i++) @(negedge clk);

    // 5: apply during SETTLE is ignored
    apply(1'b0);
    chk("busy_apply_err",  32'(bus.cfg_err), 32'd0);
    chk("busy_apply_busy", 32'(bus.cfg_busy), 32'd1);
    wait_run("l63", 0);

    // same-cycle write and apply: apply sees old k
    bus.cfg_wr    = 1'b1;
    bus.cfg_addr  = 2'd0;
    bus.cfg_wdata = 16'd5;
    sb_q.push_back(mk(20, 63, 2, 4));
    apply(1'b1);
    bus.cfg_wr = 1'b0;
    wait_run("wrapp", 4);
    sb_q.push_back(mk(5, 63, 2, 4));
    apply(1'b1);
    wait_run("k5", 4);

    // 6: reset pulse mid-SETTLE after shadow writes
    wr(2'd0, 16'd3);
    wr(2'd1, 16'd50);
    apply(1'b0);
    for (int i = 0; i < 8; i++) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    t0    = cyc;
    chk("rst2_frst", 32'(bus.filt_reset), 32'd0);
    sb_q.push_back(mk(16, 24, 1, 8));
    wait_run("rst2", 4);
    sb_q.push_back(mk(16, 24, 1, 8));
    apply(1'b1);
    wait_run("rst2_shadow", 4);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
